// File: rtl/axi_wr_arbiter_if.sv
// Bundle of all AW/W/B channel signals between the upstream masters, the arbiter
// and the shared downstream slave port.
interface axi_wr_arbiter_if #(
   parameter int NUM_M          = 2,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32
);
   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int AW_W  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 25;
   localparam int W_W   = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1;
   localparam int B_W   = AXI_ID_WIDTH + 2;

   logic [NUM_M-1:0]       s_awvalid;
   logic [NUM_M-1:0]       s_awready;
   logic [NUM_M*AW_W-1:0]  s_aw;
   logic [NUM_M-1:0]       s_wvalid;
   logic [NUM_M-1:0]       s_wready;
   logic [NUM_M*W_W-1:0]   s_w;
   logic [NUM_M-1:0]       s_bvalid;
   logic [NUM_M-1:0]       s_bready;
   logic [NUM_M*B_W-1:0]   s_b;

   logic                   m_awvalid;
   logic                   m_awready;
   logic [AW_W+IDX_W-1:0]  m_aw;
   logic                   m_wvalid;
   logic                   m_wready;
   logic [W_W-1:0]         m_w;
   logic                   m_bvalid;
   logic                   m_bready;
   logic [IDX_W+B_W-1:0]   m_b;

   // Arbiter view: upstream requests and downstream responses come in.
   modport slave (
      input  s_awvalid, s_aw, s_wvalid, s_w, s_bready,
      input  m_awready, m_wready, m_bvalid, m_b,
      output s_awready, s_wready, s_bvalid, s_b,
      output m_awvalid, m_aw, m_wvalid, m_w, m_bready
   );

   // Environment view: masters plus downstream slave model.
   modport master (
      output s_awvalid, s_aw, s_wvalid, s_w, s_bready,
      output m_awready, m_wready, m_bvalid, m_b,
      input  s_awready, s_wready, s_bvalid, s_b,
      input  m_awvalid, m_aw, m_wvalid, m_w, m_bready
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_M masters; W beats
// follow AW grant order through an order FIFO, B is routed by the ID prefix.
module axi_wr_arbiter #(
   parameter int NUM_M          = 2,
   parameter int AXI_ID_WIDTH   = 10,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int ORDER_DEPTH    = 4
) (
   input  logic            clock,
   input  logic            resetn,
   axi_wr_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int AW_W  = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 25;
   localparam int W_W   = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1;
   localparam int B_W   = AXI_ID_WIDTH + 2;
   localparam int MB_W  = IDX_W + B_W;
   localparam int PTR_W = $clog2(ORDER_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_q, state_d;
   logic [AW_W+IDX_W-1:0] aw_q, aw_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [NUM_M-1:0]      s_awready_c;
   logic                  win_found;
   logic [IDX_W-1:0]      win_idx;
   logic                  push, pop;

   logic [IDX_W-1:0]      order_mem [ORDER_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  fifo_empty, fifo_full;
   logic [IDX_W-1:0]      head;

   logic [NUM_M-1:0]      s_wready_c;
   logic                  m_wvalid_c;

   logic [IDX_W-1:0]      b_idx;
   logic [NUM_M-1:0]      s_bvalid_c;
   logic [NUM_M*B_W-1:0]  s_b_c;
   logic                  m_bready_c;

   // First pass finds a requester at/after the pointer; the second wraps around.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (!win_found && bus.s_awvalid[i] && (i >= int'(ptr_q))) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_M; i++) begin
         if (!win_found && bus.s_awvalid[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      aw_d        = aw_q;
      ptr_d       = ptr_q;
      s_awready_c = '0;
      push        = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found && !fifo_full) begin
               s_awready_c[win_idx] = 1'b1;
               aw_d    = {win_idx, bus.s_aw[win_idx*AW_W +: AW_W]};
               ptr_d   = (int'(win_idx) == NUM_M - 1) ? '0 : win_idx + 1'b1;
               push    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.m_awready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!resetn) begin
         state_q <= IDLE;
         aw_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         aw_q    <= aw_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.m_awvalid = (state_q == SEND);
   assign bus.m_aw      = aw_q;
   assign bus.s_awready = s_awready_c;

   // NOTE: FIFO storage has no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clock) begin
      if (push) order_mem[wr_ptr_q] <= win_idx;
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(ORDER_DEPTH));
   assign head       = order_mem[rd_ptr_q];

   // W channel is steered to whichever master owns the oldest outstanding AW.
   always_comb begin
      s_wready_c = '0;
      if (!fifo_empty) s_wready_c[head] = bus.m_wready;
   end

   assign m_wvalid_c   = !fifo_empty && bus.s_wvalid[head];
   assign bus.m_wvalid = m_wvalid_c;
   assign bus.m_w      = bus.s_w[head*W_W +: W_W];
   assign bus.s_wready = s_wready_c;
   assign pop          = m_wvalid_c && bus.m_wready && bus.m_w[0];

   assign b_idx = bus.m_b[MB_W-1 -: IDX_W];

   // Responses whose prefix names no master are sunk so the slave never stalls.
   always_comb begin
      s_bvalid_c = '0;
      s_b_c      = '0;
      m_bready_c = 1'b1;
      if (int'(b_idx) < NUM_M) begin
         s_bvalid_c[b_idx]          = bus.m_bvalid;
         s_b_c[b_idx*B_W +: B_W]    = bus.m_b[B_W-1:0];
         m_bready_c                 = bus.s_bready[b_idx];
      end
   end

   assign bus.s_bvalid = s_bvalid_c;
   assign bus.s_b      = s_b_c;
   assign bus.m_bready = m_bready_c;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: table of B-routing vectors plus hand-written
// sequences for AW arbitration, W ordering, FIFO full, AW stall and reset.
module tb_axi_wr_arbiter;
   localparam int NUM_M = 2;
   localparam int IDW   = 10;
   localparam int ADW   = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int AW_W  = IDW + ADW + 25;
   localparam int W_W   = DW + DW / 8 + 1;
   localparam int B_W   = IDW + 2;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   axi_wr_arbiter_if #(.NUM_M(NUM_M), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(ADW),
                       .AXI_DATA_WIDTH(DW)) bus ();

   axi_wr_arbiter #(.NUM_M(NUM_M), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(ADW),
                    .AXI_DATA_WIDTH(DW), .ORDER_DEPTH(DEPTH)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic             mbv;
      logic [IDW+2:0]   mb;
      logic [1:0]       sbr;
      logic [1:0]       sbv;
      logic [2*B_W-1:0] sb;
      logic             mbr;
   } bvec_t;

   bvec_t vecs [5];
   int    order [4];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [AW_W-1:0] mk_aw(input logic [IDW-1:0] id, input logic [ADW-1:0] addr,
                                             input logic [7:0] len);
      return {id, addr, len, 3'd2, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.s_awvalid = '0;
      bus.s_aw      = '0;
      bus.s_wvalid  = '0;
      bus.s_w       = '0;
      bus.s_bready  = '0;
      bus.m_awready = 1'b0;
      bus.m_wready  = 1'b0;
      bus.m_bvalid  = 1'b0;
      bus.m_b       = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic set_w(input int m, input logic [DW-1:0] data, input logic last);
      bus.s_w[m*W_W +: W_W] = {data, 4'hF, last};
   endtask

   initial begin
      vecs[0] = '{1'b1, {1'b0, 10'd5,   2'b00}, 2'b01, 2'b01, 24'h000014, 1'b1};
      vecs[1] = '{1'b1, {1'b1, 10'h3FF, 2'b10}, 2'b01, 2'b10, 24'hFFE000, 1'b0};
      vecs[2] = '{1'b1, {1'b1, 10'h3FF, 2'b10}, 2'b10, 2'b10, 24'hFFE000, 1'b1};
      vecs[3] = '{1'b0, {1'b0, 10'h02A, 2'b11}, 2'b11, 2'b00, 24'h0000AB, 1'b1};
      vecs[4] = '{1'b1, {1'b0, 10'h155, 2'b01}, 2'b10, 2'b01, 24'h000555, 1'b0};
      order   = '{0, 1, 0, 1};

      // Reset state, with W traffic offered so the empty FIFO must block it.
      idle_inputs();
      bus.m_wready = 1'b1;
      bus.s_wvalid = 2'b11;
      #12;
      check("rst_m_awvalid", bus.m_awvalid, 1'b0);
      check("rst_m_aw", bus.m_aw, '0);
      check("rst_s_awready", bus.s_awready, 2'b00);
      check("rst_s_wready", bus.s_wready, 2'b00);
      check("rst_m_wvalid", bus.m_wvalid, 1'b0);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      idle_inputs();
      tick();

      // B routing table.
      for (int i = 0; i < 5; i++) begin
         bus.m_bvalid = vecs[i].mbv;
         bus.m_b      = vecs[i].mb;
         bus.s_bready = vecs[i].sbr;
         #1;
         check($sformatf("bvec%0d_s_bvalid", i), bus.s_bvalid, vecs[i].sbv);
         check($sformatf("bvec%0d_s_b", i), bus.s_b, vecs[i].sb);
         check($sformatf("bvec%0d_m_bready", i), bus.m_bready, vecs[i].mbr);
      end
      idle_inputs();
      tick();

      // Single burst from M0: AW, four W beats, B response.
      bus.m_awready = 1'b1;
      bus.m_wready  = 1'b1;
      bus.s_awvalid = 2'b01;
      bus.s_aw[0 +: AW_W] = mk_aw(10'd5, 32'h100, 8'd3);
      #1;
      check("s1_s_awready", bus.s_awready, 2'b01);
      check("s1_m_awvalid_pre", bus.m_awvalid, 1'b0);
      tick();
      bus.s_awvalid = 2'b00;
      #1;
      check("s1_m_awvalid", bus.m_awvalid, 1'b1);
      check("s1_m_aw", bus.m_aw, {1'b0, mk_aw(10'd5, 32'h100, 8'd3)});
      check("s1_s_awready_send", bus.s_awready, 2'b00);
      for (int b = 0; b < 4; b++) begin
         set_w(0, 32'hA000 + b, (b == 3));
         bus.s_wvalid = 2'b01;
         #1;
         check($sformatf("s1_beat%0d_m_wvalid", b), bus.m_wvalid, 1'b1);
         check($sformatf("s1_beat%0d_m_w", b), bus.m_w, {32'hA000 + b, 4'hF, (b == 3)});
         check($sformatf("s1_beat%0d_s_wready", b), bus.s_wready, 2'b01);
         tick();
      end
      set_w(0, 32'hDEAD, 1'b0);
      #1;
      check("s1_popped_m_wvalid", bus.m_wvalid, 1'b0);
      check("s1_popped_s_wready", bus.s_wready, 2'b00);
      check("s1_idle_m_awvalid", bus.m_awvalid, 1'b0);
      bus.s_wvalid = 2'b00;
      bus.m_bvalid = 1'b1;
      bus.m_b      = {1'b0, 10'd5, 2'b00};
      bus.s_bready = 2'b01;
      #1;
      check("s1_s_bvalid", bus.s_bvalid, 2'b01);
      check("s1_bid", bus.s_b[B_W-1:0], {10'd5, 2'b00});
      check("s1_m_bready", bus.m_bready, 1'b1);
      tick();

      // Round-robin order, FIFO full, W ordering across masters, AW stall.
      do_reset();
      bus.m_awready = 1'b1;
      bus.s_aw[0 +: AW_W]    = mk_aw(10'd1, 32'h1000, 8'd0);
      bus.s_aw[AW_W +: AW_W] = mk_aw(10'd2, 32'h2000, 8'd0);
      bus.s_awvalid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr%0d_s_awready", i), bus.s_awready, 2'b01 << order[i]);
         tick();
         #1;
         check($sformatf("rr%0d_m_awvalid", i), bus.m_awvalid, 1'b1);
         check($sformatf("rr%0d_m_aw_idx", i), bus.m_aw[AW_W], order[i][0]);
         check($sformatf("rr%0d_s_awready_send", i), bus.s_awready, 2'b00);
         tick();
      end
      for (int c = 0; c < 2; c++) begin
         #1;
         check($sformatf("full%0d_s_awready", c), bus.s_awready, 2'b00);
         tick();
      end
      bus.m_wready = 1'b1;
      set_w(1, 32'hB1, 1'b1);
      bus.s_wvalid = 2'b10;
      #1;
      check("order_m1_blocked_m_wvalid", bus.m_wvalid, 1'b0);
      check("order_m1_blocked_s_wready", bus.s_wready, 2'b01);
      tick();
      set_w(0, 32'hA1, 1'b1);
      bus.s_wvalid  = 2'b11;
      bus.m_awready = 1'b0;
      #1;
      check("order_m0_m_wvalid", bus.m_wvalid, 1'b1);
      check("order_m0_m_w", bus.m_w, {32'hA1, 4'hF, 1'b1});
      check("order_m0_s_wready", bus.s_wready, 2'b01);
      check("order_full_s_awready", bus.s_awready, 2'b00);
      tick();
      #1;
      check("order_m1_m_wvalid", bus.m_wvalid, 1'b1);
      check("order_m1_m_w", bus.m_w, {32'hB1, 4'hF, 1'b1});
      check("order_m1_s_wready", bus.s_wready, 2'b10);
      check("order_unfull_s_awready", bus.s_awready, 2'b01);
      tick();
      bus.s_wvalid = 2'b00;
      for (int c = 0; c < 6; c++) begin
         #1;
         check($sformatf("stall%0d_m_awvalid", c), bus.m_awvalid, 1'b1);
         check($sformatf("stall%0d_m_aw", c), bus.m_aw, {1'b0, mk_aw(10'd1, 32'h1000, 8'd0)});
         check($sformatf("stall%0d_s_awready", c), bus.s_awready, 2'b00);
         tick();
      end
      bus.m_awready = 1'b1;
      tick();
      bus.s_awvalid = 2'b00;
      #1;
      check("stall_release_m_awvalid", bus.m_awvalid, 1'b0);
      tick();

      // B back-pressure from master 1.
      do_reset();
      bus.m_bvalid = 1'b1;
      bus.m_b      = {1'b1, 10'h00C, 2'b00};
      bus.s_bready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("bstall%0d_m_bready", c), bus.m_bready, 1'b0);
         check($sformatf("bstall%0d_s_bvalid", c), bus.s_bvalid, 2'b10);
         tick();
      end
      bus.s_bready = 2'b10;
      #1;
      check("bstall_rel_m_bready", bus.m_bready, 1'b1);
      check("bstall_rel_s_b", bus.s_b[2*B_W-1:B_W], {10'h00C, 2'b00});
      tick();
      bus.m_bvalid = 1'b0;

      // Reset in the middle of a burst.
      do_reset();
      bus.m_wready  = 1'b1;
      bus.s_awvalid = 2'b01;
      bus.s_aw[0 +: AW_W] = mk_aw(10'd7, 32'h300, 8'd3);
      #1;
      check("mid_s_awready", bus.s_awready, 2'b01);
      tick();
      bus.s_awvalid = 2'b00;
      set_w(0, 32'hC0, 1'b0);
      bus.s_wvalid = 2'b01;
      #1;
      check("mid_m_awvalid", bus.m_awvalid, 1'b1);
      check("mid_beat1_m_wvalid", bus.m_wvalid, 1'b1);
      tick();
      set_w(0, 32'hC1, 1'b0);
      #1;
      check("mid_beat2_m_wvalid", bus.m_wvalid, 1'b1);
      resetn = 1'b0;
      #1;
      check("mid_rst_m_awvalid", bus.m_awvalid, 1'b0);
      check("mid_rst_m_wvalid", bus.m_wvalid, 1'b0);
      check("mid_rst_s_wready", bus.s_wready, 2'b00);
      tick();
      #1;
      check("mid_rst_hold_m_awvalid", bus.m_awvalid, 1'b0);
      resetn = 1'b1;
      tick();
      #1;
      check("mid_post_m_wvalid", bus.m_wvalid, 1'b0);
      check("mid_post_s_wready", bus.s_wready, 2'b00);
      bus.s_wvalid  = 2'b00;
      bus.s_aw[AW_W +: AW_W] = mk_aw(10'd8, 32'h400, 8'd0);
      bus.s_awvalid = 2'b11;
      #1;
      check("mid_post_first_grant", bus.s_awready, 2'b01);
      tick();
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
